multichannel_ema_filter: RTL and testbench

// Parametrised, time-multiplexed exponential-moving-average noise filter for NUM_CH interleaved channels.
// - Each accepted sample carries a channel tag.
// - Computes y = y_prev + alpha*(x - y_prev) using per-channel state, alpha and enable.
// - Config via a register port, not RAM snooping.
// - Sits between the SPI frame deserialiser and serialiser; valid/ready on both sides gives backpressure.

---
 rtl/multichannel_ema_filter_pkg.sv | 19 +
 rtl/ema_datapath.sv | 61 ++++++
 rtl/multichannel_ema_filter.sv | 181 ++++++++++++++++++
 tb/tb_multichannel_ema_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_ema_filter_pkg.sv
// Shared definitions for the multichannel EMA filter: register map,
// CTRL bit positions and reset defaults.
package multichannel_ema_filter_pkg;

  // Register selector carried in the low two bits of cfg_addr.
  typedef enum logic [1:0] {
    REG_ALPHA = 2'd0,
    REG_CTRL  = 2'd1,
    REG_STATE = 2'd2,
    REG_COUNT = 2'd3
  } cfg_reg_e;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_CLR_BIT        = 1;
  localparam int ALPHA_RESET_DEFAULT = 8192;
  localparam int CFG_DATA_W          = 32;
  localparam int COUNT_W             = 16;

endpackage

// File: rtl/ema_datapath.sv
// Combinational EMA step: y = y_prev + round(alpha * (x - y_prev)),
// with alpha in Q1.(ALPHA_W-1), round half up, result saturated to DATA_W.
module ema_datapath #(
  parameter int DATA_W  = 16,
  parameter int ALPHA_W = 16
) (
  input  logic signed [DATA_W-1:0]  i_x,
  input  logic signed [DATA_W-1:0]  i_y_prev,
  input  logic        [ALPHA_W-1:0] i_alpha,
  output logic signed [DATA_W-1:0]  o_y
);

  // Working width holds the full signed product of a DATA_W+1 difference
  // and a zero-extended alpha without any loss.
  localparam int PW = DATA_W + ALPHA_W + 2;

  localparam logic signed [PW-1:0] RND_HALF =
    {{(PW-ALPHA_W+1){1'b0}}, 1'b1, {(ALPHA_W-2){1'b0}}};
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Add half an LSB of the output scale, then drop the fraction bits.
  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] v);
    round_shift = (v + RND_HALF) >>> (ALPHA_W-1);
  endfunction

  // Clamp to the signed DATA_W range; with alpha < 1 this never triggers,
  // it only guards against out-of-range results.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)
      saturate = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_MIN)
      saturate = {1'b1, {(DATA_W-1){1'b0}}};
    else
      saturate = v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0] w_x_ext;
  logic signed [DATA_W:0] w_y_ext1;
  logic signed [DATA_W:0] w_diff;
  logic signed [PW-1:0]   w_diff_ext;
  logic signed [PW-1:0]   w_alpha_ext;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_step;
  logic signed [PW-1:0]   w_y_ext;
  logic signed [PW-1:0]   w_sum;

  assign w_x_ext     = {i_x[DATA_W-1], i_x};
  assign w_y_ext1    = {i_y_prev[DATA_W-1], i_y_prev};
  assign w_diff      = w_x_ext - w_y_ext1;
  assign w_diff_ext  = {{(PW-DATA_W-1){w_diff[DATA_W]}}, w_diff};
  assign w_alpha_ext = {{(PW-ALPHA_W){1'b0}}, i_alpha};
  assign w_prod      = w_diff_ext * w_alpha_ext;
  assign w_step      = round_shift(w_prod);
  assign w_y_ext     = {{(PW-DATA_W){i_y_prev[DATA_W-1]}}, i_y_prev};
  assign w_sum       = w_y_ext + w_step;
  assign o_y         = saturate(w_sum);

endmodule

// File: rtl/multichannel_ema_filter.sv
// Time-multiplexed EMA noise filter for NUM_CH interleaved channels.
// Two-stage pipeline (S1 capture, output register) with valid/ready on both
// sides, per-channel alpha/enable/state and a small register port.
module multichannel_ema_filter
  import multichannel_ema_filter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int ALPHA_W     = 16,
  parameter int ALPHA_RESET = ALPHA_RESET_DEFAULT,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [CH_W-1:0]       in_ch,
  input  logic signed [DATA_W-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [CH_W-1:0]       out_ch,
  output logic signed [DATA_W-1:0]     out_data,
  input  logic                         cfg_we,
  input  logic                         cfg_re,
  input  logic        [CH_W+1:0]       cfg_addr,
  input  logic        [CFG_DATA_W-1:0] cfg_wdata,
  output logic        [CFG_DATA_W-1:0] cfg_rdata
);

  localparam logic [ALPHA_W-1:0] ALPHA_MAX = {1'b0, {(ALPHA_W-1){1'b1}}};

  // Per-channel configuration and filter state.
  logic        [ALPHA_W-1:0] r_alpha  [NUM_CH];
  logic signed [DATA_W-1:0]  r_yprev  [NUM_CH];
  logic        [COUNT_W-1:0] r_count  [NUM_CH];
  logic        [NUM_CH-1:0]  r_en;
  logic        [NUM_CH-1:0]  r_primed;

  // S1 pipeline register: sample plus the alpha/en seen at accept time.
  logic                      r_s1_vld;
  logic        [CH_W-1:0]    r_s1_ch;
  logic signed [DATA_W-1:0]  r_s1_x;
  logic        [ALPHA_W-1:0] r_s1_alpha;
  logic                      r_s1_en;

  logic                      w_hold;
  logic                      w_accept;
  logic                      w_commit;
  logic signed [DATA_W-1:0]  w_s1_yprev;
  logic                      w_s1_primed;
  logic signed [DATA_W-1:0]  w_dp_y;
  logic signed [DATA_W-1:0]  w_result;

  logic        [CH_W-1:0]    w_cfg_ch;
  cfg_reg_e                  w_cfg_reg;
  logic                      w_wr_alpha;
  logic                      w_wr_ctrl;
  logic                      w_wr_count;
  logic        [ALPHA_W-1:0] w_alpha_wval;
  logic        [CFG_DATA_W-1:0] w_rd_mux;
  logic                      w_unused_wdata;

  // Handshake: a full output that is not being taken freezes both stages.
  assign w_hold   = out_valid && !out_ready;
  assign in_ready = !r_s1_vld || !w_hold;
  assign w_accept = in_valid && in_ready;
  assign w_commit = r_s1_vld && !w_hold;

  // Config decode.
  assign w_cfg_ch     = cfg_addr[CH_W+1:2];
  assign w_cfg_reg    = cfg_reg_e'(cfg_addr[1:0]);
  assign w_wr_alpha   = cfg_we && (w_cfg_reg == REG_ALPHA);
  assign w_wr_ctrl    = cfg_we && (w_cfg_reg == REG_CTRL);
  assign w_wr_count   = cfg_we && (w_cfg_reg == REG_COUNT);
  assign w_alpha_wval = cfg_wdata[ALPHA_W-1] ? ALPHA_MAX : cfg_wdata[ALPHA_W-1:0];
  assign w_unused_wdata = ^cfg_wdata[CFG_DATA_W-1:ALPHA_W];

  // Stage S1: state lookup for the channel in flight, then the EMA step.
  assign w_s1_yprev  = r_yprev[r_s1_ch];
  assign w_s1_primed = r_primed[r_s1_ch];

  ema_datapath #(
    .DATA_W  (DATA_W),
    .ALPHA_W (ALPHA_W)
  ) u_datapath (
    .i_x      (r_s1_x),
    .i_y_prev (w_s1_yprev),
    .i_alpha  (r_s1_alpha),
    .o_y      (w_dp_y)
  );

  // First sample of a channel and disabled channels pass x straight through.
  assign w_result = (w_s1_primed && r_s1_en) ? w_dp_y : r_s1_x;

  // Capture accepted samples into S1; frozen while held with S1 occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_x     <= '0;
      r_s1_alpha <= '0;
      r_s1_en    <= 1'b0;
    end else if (in_ready) begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_ch    <= in_ch;
        r_s1_x     <= in_data;
        r_s1_alpha <= r_alpha[in_ch];
        r_s1_en    <= r_en[in_ch];
      end
    end
  end

  // Stage output: register the result of S1 unless the consumer is stalling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (!w_hold) begin
      out_valid <= r_s1_vld;
      if (r_s1_vld) begin
        out_ch   <= r_s1_ch;
        out_data <= w_result;
      end
    end
  end

  // Per-channel state: result commit first, so a coincident clear or COUNT
  // write takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_alpha[c]  <= ALPHA_W'(ALPHA_RESET);
        r_yprev[c]  <= '0;
        r_count[c]  <= '0;
        r_en[c]     <= 1'b1;
        r_primed[c] <= 1'b0;
      end
    end else begin
      if (w_commit) begin
        r_yprev[r_s1_ch]  <= w_result;
        r_primed[r_s1_ch] <= 1'b1;
        r_count[r_s1_ch]  <= r_count[r_s1_ch] + COUNT_W'(1);
      end
      if (w_wr_alpha)
        r_alpha[w_cfg_ch] <= w_alpha_wval;
      if (w_wr_ctrl) begin
        r_en[w_cfg_ch] <= cfg_wdata[CTRL_EN_BIT];
        if (cfg_wdata[CTRL_CLR_BIT]) begin
          r_yprev[w_cfg_ch]  <= '0;
          r_primed[w_cfg_ch] <= 1'b0;
        end
      end
      if (w_wr_count)
        r_count[w_cfg_ch] <= '0;
    end
  end

  // Read mux over current register values; a same-cycle write is not yet visible.
  always_comb begin
    w_rd_mux = '0;
    case (w_cfg_reg)
      REG_ALPHA: w_rd_mux = {{(CFG_DATA_W-ALPHA_W){1'b0}}, r_alpha[w_cfg_ch]};
      REG_CTRL:  w_rd_mux = {{(CFG_DATA_W-1){1'b0}}, r_en[w_cfg_ch]};
      REG_STATE: w_rd_mux = {{(CFG_DATA_W-DATA_W){r_yprev[w_cfg_ch][DATA_W-1]}},
                             r_yprev[w_cfg_ch]};
      REG_COUNT: w_rd_mux = {{(CFG_DATA_W-COUNT_W){1'b0}}, r_count[w_cfg_ch]};
      default:   w_rd_mux = '0;
    endcase
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cfg_rdata <= '0;
    else if (cfg_re)
      cfg_rdata <= w_rd_mux;
  end

endmodule

// File: tb/tb_multichannel_ema_filter.sv
// Directed bench for multichannel_ema_filter (NUM_CH=4, DATA_W=16, ALPHA_W=16).
module tb_multichannel_ema_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;
  logic               cfg_we;
  logic               cfg_re;
  logic [3:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int ich  [6] = '{0, 1, 0, 1, 0, 1};
  int idat [6] = '{0, 400, 1000, 0, 1000, 0};
  int iexp [6] = '{0, 400, 250, 300, 438, 225};

  always #5 clk = ~clk;

  multichannel_ema_filter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    chk(tag, cfg_rdata, exp);
  endtask

  // One sample in, result checked exactly two edges after it is offered.
  task automatic send(input logic [1:0] ch, input logic [15:0] x,
                      input logic [15:0] exp, input string tag);
    in_valid = 1'b1; in_ch = ch; in_data = x;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ch"}, {30'd0, out_ch}, {30'd0, ch});
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
  endtask

  initial begin
    int idx, got;
    logic acc, fire, saw_stall, prev_hold;
    logic [15:0] prev_data;

    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cfg_chk(4'd0, 32'd8192, "rst_alpha_ch0");
    cfg_chk(4'd1, 32'd1, "rst_ctrl_ch0");

    // Basic EMA on ch0 with alpha = 0.25.
    send(2'd0, 16'd0, 16'd0, "t1_s0");
    send(2'd0, 16'd1000, 16'd250, "t1_s1");
    send(2'd0, 16'd1000, 16'd438, "t1_s2");
    cfg_chk(4'd3, 32'd3, "t1_count");
    cfg_wr(4'd3, 32'd0);
    cfg_chk(4'd3, 32'd0, "t1_count_wr");
    cfg_chk(4'd2, 32'd438, "t1_state");

    // Interleaved ch0/ch1 at full rate; ch0 cleared first so it re-primes.
    cfg_wr(4'd1, 32'd3);
    cfg_chk(4'd2, 32'd0, "t2_clr_state");
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_ch = 2'(ich[k]); in_data = 16'(idat[k]);
      #1;
      chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (k > 0) begin
        chk("t2_vld", {31'd0, out_valid}, 32'd1);
        chk("t2_ch", {30'd0, out_ch}, 32'(ich[k-1]));
        chk("t2_data", {16'd0, out_data}, 32'(iexp[k-1]));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t2_last_ch", {30'd0, out_ch}, 32'd1);
    chk("t2_last_data", {16'd0, out_data}, 32'd225);
    tick();

    // Backpressure on bypassed ch3: values 10..80 must emerge once each, in order.
    cfg_wr(4'd13, 32'd0);
    idx = 0; got = 0; saw_stall = 1'b0; prev_hold = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = (idx < 8);
      in_ch     = 2'd3;
      in_data   = 16'(10 * (idx + 1));
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        chk("t3_data", {16'd0, out_data}, 32'(10 * (got + 1)));
        chk("t3_ch", {30'd0, out_ch}, 32'd3);
        got++;
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && !out_ready && prev_hold)
        chk("t3_hold_stable", {16'd0, out_data}, {16'd0, prev_data});
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3_all_out", 32'(got), 32'd8);
    chk("t3_all_in", 32'(idx), 32'd8);
    chk("t3_saw_stall", {31'd0, saw_stall}, 32'd1);
    tick(); tick();
    chk("t3_drained", {31'd0, out_valid}, 32'd0);

    // Enable control on ch2: bypass keeps y_prev tracking x.
    send(2'd2, 16'd0, 16'd0, "t4_prime");
    cfg_wr(4'd9, 32'd0);
    send(2'd2, 16'd1234, 16'd1234, "t4_off");
    cfg_wr(4'd9, 32'd1);
    send(2'd2, 16'd1234, 16'd1234, "t4_on");
    send(2'd2, 16'd1634, 16'd1334, "t4_step");
    cfg_chk(4'd10, 32'd1334, "t4_state");

    // Alpha clamp, clear coincident with commit, write+read same cycle.
    cfg_wr(4'd4, 32'h0000_FFFF);
    cfg_chk(4'd4, 32'h0000_7FFF, "t5_alpha_clamp");
    in_valid = 1'b1; in_ch = 2'd1; in_data = 16'sd1225;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 32'd3;
    tick();
    cfg_we = 1'b0;
    chk("t5_clr_vld", {31'd0, out_valid}, 32'd1);
    chk("t5_clr_data", {16'd0, out_data}, 32'd1225);
    cfg_chk(4'd6, 32'd0, "t5_clr_state");
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 4'd4; cfg_wdata = 32'd8192;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("t5_rw_prewrite", cfg_rdata, 32'h0000_7FFF);
    cfg_chk(4'd4, 32'd8192, "t5_rw_after");
    send(2'd1, 16'd500, 16'd500, "t5_reprime");

    // Reset with both stages full.
    cfg_wr(4'd12, 32'd1000);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd5;
    tick();
    in_data = 16'sd6;
    tick();
    in_valid = 1'b0;
    chk("t6_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_full_vld", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", {16'd0, out_data}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("t6_no_partial", {31'd0, out_valid}, 32'd0);
    cfg_chk(4'd12, 32'd8192, "t6_alpha_rst");
    cfg_chk(4'd3, 32'd0, "t6_count_rst");
    cfg_chk(4'd13, 32'd1, "t6_en_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
